// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: CP0 SR/Cause/EPC/PRId with interrupt and exception entry; define CP0_EXC_EN to accept ExcIn traps
module cp0_int_ctrl #(
    parameter logic [31:0] PRID = 32'h0000_4D49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Sel,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic        EXLClr,
    input  logic [29:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcIn,
    input  logic [5:0]  HWInt,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);
    logic [5:0]  im_q, im_d, ip_q, ip_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d, exc_code;
    logic [29:0] epc_q, epc_d;
    logic        int_pend, exc_pend, sr_we, epc_we;
`ifdef CP0_EXC_EN
    assign exc_pend = (ExcIn != 5'd0) & ~exl_q;
    assign exc_code = ExcIn;
`else
    logic unused_exc_in;
    assign unused_exc_in = ^ExcIn;
    assign exc_pend = 1'b0;
    assign exc_code = 5'd0;
`endif
    assign int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign IntReq   = int_pend | exc_pend;
    assign EPC      = epc_q;
    // next state: trap entry overrides mtc0 (flushed); eret beats an SR write's EXL bit
    always_comb begin
        sr_we      = We & ~IntReq & (Sel == 5'd12);
        epc_we     = We & ~IntReq & (Sel == 5'd14);
        ip_d       = HWInt;
        im_d       = sr_we ? DIn[15:10] : im_q;
        ie_d       = sr_we ? DIn[0] : ie_q;
        exl_d      = IntReq ? 1'b1 : EXLClr ? 1'b0 : sr_we ? DIn[1] : exl_q;
        bd_d       = IntReq ? BD : bd_q;
        exc_code_d = IntReq ? (int_pend ? 5'd0 : exc_code) : exc_code_q;
        epc_d      = IntReq ? (BD ? PC - 30'd1 : PC) : epc_we ? DIn[31:2] : epc_q;
    end
    // mfc0 read mux
    always_comb begin
        DOut = (Sel == 5'd12) ? {16'd0, im_q, 8'd0, exl_q, ie_q} :
               (Sel == 5'd13) ? {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0} :
               (Sel == 5'd14) ? {epc_q, 2'd0} :
               (Sel == 5'd15) ? PRID : 32'd0;
    end
    // register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            ip_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            im_q       <= im_d;
            ip_q       <= ip_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb_cp0_int_ctrl: directed vector table plus hand sequences for cp0_int_ctrl
module tb_cp0_int_ctrl;
    localparam logic [31:0] PRID = 32'h0000_4D49;
`ifdef CP0_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset, We, EXLClr, BD, IntReq;
    logic [4:0]  Sel, ExcIn;
    logic [31:0] DIn, DOut;
    logic [29:0] PC, EPC;
    logic [5:0]  HWInt;
    int applied = 0;
    int errs = 0;

    typedef struct {
        logic        rst;
        logic [4:0]  sel;
        logic [31:0] din;
        logic        we;
        logic        clr;
        logic [29:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        req;
        logic [29:0] epc;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[$];

    cp0_int_ctrl #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .Sel(Sel), .DIn(DIn), .We(We), .EXLClr(EXLClr),
        .PC(PC), .BD(BD), .ExcIn(ExcIn), .HWInt(HWInt),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [4:0] sel, input logic [31:0] din,
                                input logic we, input logic clr, input logic [29:0] pc, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw, input logic req,
                                input logic [29:0] epc, input logic [31:0] dout);
        vec_t v;
        v.rst = rst; v.sel = sel; v.din = din; v.we = we; v.clr = clr; v.pc = pc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.req = req; v.epc = epc; v.dout = dout;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; Sel = v.sel; DIn = v.din; We = v.we; EXLClr = v.clr;
        PC = v.pc; BD = v.bd; ExcIn = v.exc; HWInt = v.hw;
        #1;
        applied++;
        if (IntReq !== v.req) begin
            errs++;
            $display("FAIL %s IntReq got %b expected %b", tag, IntReq, v.req);
        end
        if (EPC !== v.epc) begin
            errs++;
            $display("FAIL %s EPC got %h expected %h", tag, EPC, v.epc);
        end
        if (DOut !== v.dout) begin
            errs++;
            $display("FAIL %s DOut(sel %0d) got %h expected %h", tag, v.sel, DOut, v.dout);
        end
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; Sel = 5'd0; DIn = 32'd0; We = 1'b0; EXLClr = 1'b0;
        PC = 30'd0; BD = 1'b0; ExcIn = 5'd0; HWInt = 6'd0;
        repeat (2) @(posedge clk);
        // rst sel din we clr pc bd exc hw | req epc dout
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h3f, 0, 0, 0));
        tbl.push_back(mk(0, 15, 0, 0, 0, 0, 0, 0, 6'h3f, 0, 0, PRID));
        tbl.push_back(mk(0, 12, 32'h401, 1, 0, 0, 0, 0, 6'h01, 0, 0, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 30'h0C01, 0, 0, 6'h01, 1, 0, 32'h400));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h01, 0, 30'h0C01, 32'h3004));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h01, 0, 30'h0C01, 32'h403));
        tbl.push_back(mk(0, 13, 0, 0, 1, 0, 0, 0, 6'h01, 0, 30'h0C01, 32'h400));
        tbl.push_back(mk(0, 12, 0, 0, 0, 30'h0C02, 1, 0, 6'h01, 1, 30'h0C01, 32'h401));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h01, 0, 30'h0C01, 32'h8000_0400));
        tbl.push_back(mk(0, 14, 0, 0, 1, 0, 0, 0, 6'h01, 0, 30'h0C01, 32'h3004));
        tbl.push_back(mk(0, 14, 32'h3010, 1, 0, 30'h0C03, 0, 0, 6'h01, 1, 30'h0C01, 32'h3004));
        tbl.push_back(mk(0, 14, 32'h3010, 1, 0, 0, 0, 0, 6'h00, 0, 30'h0C03, 32'h300C));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 30'h0C04, 32'h3010));
        tbl.push_back(mk(0, 12, 32'hC03, 1, 1, 0, 0, 0, 6'h00, 0, 30'h0C04, 32'h403));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 30'h0C04, 32'hC01));
        tbl.push_back(mk(0, 12, 0, 0, 0, 30'h100, 0, 0, 6'h02, 1, 30'h0C04, 32'hC01));
        tbl.push_back(mk(0, 13, 0, 0, 1, 0, 0, 10, 6'h02, 0, 30'h100, 32'h800));
        tbl.push_back(mk(0, 13, 0, 0, 0, 30'h200, 0, 10, 6'h02, 1, 30'h100, 32'h800));
        tbl.push_back(mk(0, 13, 0, 0, 1, 0, 0, 0, 6'h00, 0, 30'h200, 32'h800));
        tbl.push_back(mk(0, 13, 0, 0, 0, 30'h300, 0, 10, 6'h04, EXC, 30'h200, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 30'h400, 0, 0, 6'h01, !EXC,
                         EXC ? 30'h300 : 30'h200, EXC ? 32'h1028 : 32'h1000));
        tbl.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0,
                         EXC ? 30'h300 : 30'h400, EXC ? 32'h428 : 32'h400));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h3f, 0, 0, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
        tbl.push_back(mk(0, 15, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, PRID));
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
        // EPC wrap on a delay-slot trap at PC 0, held line with no re-entry, then eret re-entry
        apply(mk(0, 12, 32'h401, 1, 0, 0, 0, 0, 6'h01, 0, 0, 0), "wrap_sr");
        apply(mk(0, 14, 0, 0, 0, 0, 1, 0, 6'h01, 1, 0, 0), "wrap_trap");
        apply(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h01, 0, 30'h3FFF_FFFF, 32'hFFFF_FFFC), "wrap_epc");
        apply(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h01, 0, 30'h3FFF_FFFF, 32'hFFFF_FFFC), "held_noreent");
        apply(mk(0, 14, 0, 0, 1, 0, 0, 0, 6'h01, 0, 30'h3FFF_FFFF, 32'hFFFF_FFFC), "held_eret");
        apply(mk(0, 12, 0, 0, 0, 30'd5, 0, 0, 6'h01, 1, 30'h3FFF_FFFF, 32'h401), "held_reent");
        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end
endmodule
